ext_mem_model: RTL

EXT_MEM_MODEL -- requirements
Module: ext_mem_model

---
 rtl/ext_mem_model_pkg.sv | 19 +
 rtl/ext_mem_array.sv | 28 ++
 rtl/ext_mem_model.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ext_mem_model_pkg.sv
// Shared memory-channel widths (processor-side const.vh values) and the
// ext_mem_model FSM state encodings.
package ext_mem_model_pkg;

  localparam int MEM_ADDR_BITS   = 26;
  localparam int MEM_DATA_BITS   = 128;
  localparam int MEM_TAG_BITS    = 5;
  localparam int MEM_DATA_CYCLES = 4;
  localparam int MEM_MASK_BITS   = MEM_DATA_BITS / 8;
  localparam int BEAT_W          = $clog2(MEM_DATA_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_DATA  = 2'd1,
    RD_WAIT  = 2'd2,
    RD_BURST = 2'd3
  } state_t;

endpackage

// File: rtl/ext_mem_array.sv
// Backing store for ext_mem_model: one byte-enabled write port and one
// synchronous read port, depth 2^ADDR_W words.
module ext_mem_array #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 128,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the storage array has no reset on purpose; contents must survive a
  // reset, and a reset on a RAM prevents mapping it onto memory macros.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (wr_en && wr_be[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ext_mem_model.sv
// Burst memory model for the processor memory channel: 4-beat bursts, fixed
// read latency. Define EXT_MEM_MODEL_WMASK_EN to honour write byte masks.
module ext_mem_model
  import ext_mem_model_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int RD_LATENCY = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_req_valid,
  output logic                     mem_req_ready,
  input  logic                     mem_req_rw,
  input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  input  logic [MEM_TAG_BITS-1:0]  mem_req_tag,
  input  logic                     mem_req_data_valid,
  output logic                     mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
  input  logic [MEM_MASK_BITS-1:0] mem_req_data_mask,
  output logic                     mem_resp_valid,
  output logic [MEM_TAG_BITS-1:0]  mem_resp_tag,
  output logic [MEM_DATA_BITS-1:0] mem_resp_data
);

  state_t                  state, state_nxt;
  logic [7:0]              lat_cnt, lat_cnt_nxt;
  logic [BEAT_W-1:0]       beat, beat_nxt, rd_beat;
  logic [ADDR_W-3:0]       addr_hi;
  logic [MEM_TAG_BITS-1:0] tag_q;
  logic                    wr_en, resp_valid;
  logic [MEM_MASK_BITS-1:0] wr_be;
  logic [MEM_DATA_BITS-1:0] rd_data;
  logic                    unused_addr_bits;

  // Bits above the store depth alias; the low two bits come from the beat counter.
  assign unused_addr_bits = ^{mem_req_addr[MEM_ADDR_BITS-1:ADDR_W], mem_req_addr[1:0]};

`ifdef EXT_MEM_MODEL_WMASK_EN
  assign wr_be = mem_req_data_mask;
`else
  logic unused_mask;
  assign unused_mask = ^mem_req_data_mask;
  assign wr_be       = '1;
`endif

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt          = state;
    lat_cnt_nxt        = lat_cnt;
    beat_nxt           = beat;
    mem_req_ready      = 1'b0;
    mem_req_data_ready = 1'b0;
    wr_en              = 1'b0;
    resp_valid         = 1'b0;
    case (state)
      IDLE: begin
        mem_req_ready = 1'b1;
        if (mem_req_valid) begin
          beat_nxt = '0;
          if (mem_req_rw) begin
            state_nxt = WR_DATA;
          end else begin
            state_nxt   = RD_WAIT;
            lat_cnt_nxt = 8'(RD_LATENCY - 1);
          end
        end
      end
      WR_DATA: begin
        mem_req_data_ready = 1'b1;
        if (mem_req_data_valid) begin
          wr_en    = 1'b1;
          beat_nxt = beat + BEAT_W'(1);
          if (beat == BEAT_W'(MEM_DATA_CYCLES - 1)) state_nxt = IDLE;
        end
      end
      RD_WAIT: begin
        if (lat_cnt == 8'd0) state_nxt = RD_BURST;
        else                 lat_cnt_nxt = lat_cnt - 8'd1;
      end
      RD_BURST: begin
        resp_valid = 1'b1;
        beat_nxt   = beat + BEAT_W'(1);
        if (beat == BEAT_W'(MEM_DATA_CYCLES - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lat_cnt <= '0;
      beat    <= '0;
      addr_hi <= '0;
      tag_q   <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      beat    <= beat_nxt;
      if (state == IDLE && mem_req_valid) begin
        addr_hi <= mem_req_addr[ADDR_W-1:2];
        tag_q   <= mem_req_tag;
      end
    end
  end

  // The read port runs one beat ahead so each beat's data is ready on its cycle.
  assign rd_beat = (state == RD_BURST) ? beat + BEAT_W'(1) : '0;

  ext_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (MEM_DATA_BITS),
    .BE_W   (MEM_MASK_BITS)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr ({addr_hi, beat}),
    .wr_data (mem_req_data_bits),
    .wr_be   (wr_be),
    .rd_addr ({addr_hi, rd_beat}),
    .rd_data (rd_data)
  );

  assign mem_resp_valid = resp_valid;
  assign mem_resp_tag   = resp_valid ? tag_q   : '0;
  assign mem_resp_data  = resp_valid ? rd_data : '0;

endmodule
